// File: rtl/bram_sdp.sv
// Simple dual-port block RAM: one write port, one registered read port.
// Read-before-write on address collision; reset clears only the read register.
module bram_sdp #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Zero contents and a zero read register from configuration onward.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] rdata_q = '0;

  // Write port; deliberately independent of reset so that a write
  // issued alongside reset still lands and contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en)
      mem[i_waddr] <= i_wdata;
  end

  // Read port; the non-blocking read sees the pre-write word on a
  // same-address collision. Reset wins over a concurrent read.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      rdata_q <= '0;
    else if (i_rd_en)
      rdata_q <= mem[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: tb/tb_bram_sdp.sv
// Bench for bram_sdp: directed vector table plus a randomised burst,
// both checked through a reference memory and a read scoreboard.
module tb_bram_sdp;

  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] raddr = '0;
  logic [DW-1:0] rdata;

  bram_sdp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_wr_en (wr_en),
    .i_waddr (waddr),
    .i_wdata (wdata),
    .i_rd_en (rd_en),
    .i_raddr (raddr),
    .o_rdata (rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic          chk;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          tbl[$];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] model [2**AW];
  logic [DW-1:0] exp_q;
  int            n_vec = 0;
  int            n_bad = 0;

  function automatic vec_t mk(
    input logic r, input logic we, input logic [AW-1:0] wa,
    input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
    input logic c, input logic [DW-1:0] e);
    vec_t v;
    v.rst = r; v.we = we; v.wa = wa; v.wd = wd;
    v.re = re; v.ra = ra; v.chk = c; v.exp = e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    rst   = v.rst;
    wr_en = v.we;
    waddr = v.wa;
    wdata = v.wd;
    rd_en = v.re;
    raddr = v.ra;
    if (v.re && !v.rst) sb.push_back(model[v.ra]);
    if (v.we) model[v.wa] = v.wd;
    @(posedge clk);
    #1;
    if (v.rst) exp_q = '0;
    else if (v.re) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s: scoreboard empty, got %h want entry", nm, rdata);
      end else exp_q = sb.pop_front();
    end
    check({nm, "_sb"}, rdata, exp_q);
    if (v.chk) check({nm, "_tbl"}, rdata, v.exp);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) model[i] = '0;
    exp_q = '0;

    #1;
    check("powerup", rdata, 16'h0000);

    tbl.push_back(mk(1, 0, 8'h00, 16'h0000, 1, 8'h00, 1, 16'h0000));
    tbl.push_back(mk(0, 1, 8'hFF, 16'hBE11, 0, 8'h00, 1, 16'h0000));
    tbl.push_back(mk(0, 1, 8'h95, 16'hC0DE, 0, 8'h00, 0, 16'h0000));
    tbl.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 8'hFF, 1, 16'hBE11));
    tbl.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 8'h95, 1, 16'hC0DE));
    tbl.push_back(mk(0, 1, 8'hFF, 16'hFADE, 1, 8'h95, 1, 16'hC0DE));
    tbl.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 8'hFF, 1, 16'hFADE));
    tbl.push_back(mk(0, 1, 8'hFF, 16'hDEAD, 1, 8'hFF, 1, 16'hFADE));
    tbl.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 8'hFF, 1, 16'hDEAD));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 8'h00, 16'h0000, 0, 8'h95, 1, 16'hDEAD));
    tbl.push_back(mk(1, 0, 8'h00, 16'h0000, 1, 8'hFF, 1, 16'h0000));
    tbl.push_back(mk(0, 0, 8'h00, 16'h0000, 0, 8'h00, 1, 16'h0000));
    tbl.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 8'hFF, 1, 16'hDEAD));
    tbl.push_back(mk(0, 1, 8'h00, 16'h1234, 0, 8'h00, 1, 16'hDEAD));
    tbl.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 8'h00, 1, 16'h1234));
    tbl.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 8'h01, 1, 16'h0000));
    tbl.push_back(mk(1, 1, 8'h10, 16'h5A5A, 1, 8'h10, 1, 16'h0000));
    tbl.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 8'h10, 1, 16'h5A5A));
    tbl.push_back(mk(0, 1, 8'h01, 16'h0F0F, 1, 8'hFF, 1, 16'hDEAD));
    tbl.push_back(mk(0, 0, 8'h00, 16'h0000, 1, 8'h01, 1, 16'h0F0F));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 400; i++) begin
      vec_t v;
      v.rst = ($urandom_range(0, 31) == 0);
      v.we  = $urandom_range(0, 1);
      v.wa  = ($urandom_range(0, 3) == 0) ? 8'(8'hF8 + $urandom_range(0, 7))
                                          : 8'($urandom_range(0, 7));
      v.wd  = 16'($urandom);
      v.re  = ($urandom_range(0, 3) != 0);
      v.ra  = ($urandom_range(0, 3) == 0) ? 8'(8'hF8 + $urandom_range(0, 7))
                                          : 8'($urandom_range(0, 7));
      v.chk = 1'b0;
      v.exp = '0;
      apply(v, $sformatf("rnd%0d", i));
    end

    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d left want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
